counter_input_conditioner: RTL and testbench

// - Upstream stage of the tt_um_prampal_counter datapath. Conditions three raw, asynchronous

---
 rtl/counter_input_conditioner.sv | 146 ++++++++++++++
 tb/tb_counter_input_conditioner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_input_conditioner.sv
// Conditions the raw increment/decrement/clear pushbuttons into arbitrated single-cycle strobes.
// Define COUNTER_INPUT_AUTO_REPEAT_EN to add hold-to-repeat on the increment and decrement channels.
module counter_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 256,
    parameter int REPEAT_PERIOD   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_clr,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       clr_pulse,
    output logic [2:0] btn_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("counter_input_conditioner: invalid DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    // Channel order everywhere is {clr, dec, inc}
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       level;
    logic [2:0]       level_d;
    logic [2:0]       rise_q;
    logic [CNT_W-1:0] deb_cnt [3];
    logic [1:0]       rep_req;
    logic [2:0]       req;

    assign raw       = {btn_clr, btn_dec, btn_inc};
    assign btn_level = level;

    // A level is only accepted after the synced input has disagreed with it for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            rise_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            rise_q  <= level & ~level_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]   <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef COUNTER_INPUT_AUTO_REPEAT_EN
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    rep_state_t       rep_state [2];
    logic [TMR_W-1:0] rep_tmr   [2];

    // Request is suppressed once the debounced level drops, so release never yields a strobe
    always_comb begin
        rep_req = '0;
        for (int i = 0; i < 2; i++) begin
            rep_req[i] = level[i] &&
                         ((rep_state[i] == DELAY  && rep_tmr[i] == TMR_W'(REPEAT_DELAY - 1)) ||
                          (rep_state[i] == REPEAT && rep_tmr[i] == TMR_W'(REPEAT_PERIOD - 1)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rep_state[i] <= IDLE;
                rep_tmr[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!level[i]) begin
                    rep_state[i] <= IDLE;
                    rep_tmr[i]   <= '0;
                end else begin
                    case (rep_state[i])
                        IDLE: begin
                            if (rise_q[i]) begin
                                rep_state[i] <= DELAY;
                                rep_tmr[i]   <= '0;
                            end
                        end
                        DELAY, REPEAT: begin
                            if (rep_req[i]) begin
                                rep_state[i] <= REPEAT;
                                rep_tmr[i]   <= '0;
                            end else if (rep_tmr[i] != '1) begin
                                rep_tmr[i] <= rep_tmr[i] + 1'b1;
                            end
                        end
                        default: begin
                            rep_state[i] <= IDLE;
                            rep_tmr[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end
`else
    assign rep_req = '0;
`endif

    assign req = {rise_q[2], rise_q[1] | rep_req[1], rise_q[0] | rep_req[0]};

    // Clear wins outright; simultaneous increment and decrement cancel each other
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            clr_pulse <= 1'b0;
        end else begin
            clr_pulse <= req[2];
            inc_pulse <= req[0] & ~req[1] & ~req[2];
            dec_pulse <= req[1] & ~req[0] & ~req[2];
        end
    end

endmodule

// File: tb/tb_counter_input_conditioner.sv
// Scoreboard bench for counter_input_conditioner; expected strobes are queued when buttons are driven.
// Honours COUNTER_INPUT_AUTO_REPEAT_EN when predicting repeat strobes.
module tb_counter_input_conditioner;

    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_inc;
    logic       btn_dec;
    logic       btn_clr;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       clr_pulse;
    logic [2:0] btn_level;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } exp_t;

    exp_t sbq[$];

    counter_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_inc  (btn_inc),
        .btn_dec  (btn_dec),
        .btn_clr  (btn_clr),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .clr_pulse(clr_pulse),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic inc, input logic dec, input logic clr);
        btn_inc = inc;
        btn_dec = dec;
        btn_clr = clr;
    endtask

    // Button(s) go high at the negedge where cyc == c and stay high for h cycles
    function automatic void pushPress(input logic [2:0] kind, input int c, input int h);
        exp_t e;
        int   p;
        p      = c + DEB + 4;
        e.cyc  = p;
        e.kind = kind;
        sbq.push_back(e);
`ifdef COUNTER_INPUT_AUTO_REPEAT_EN
        if (kind != 3'b100) begin
            p += RDLY;
            while (p <= c + h + DEB + 2) begin
                e.cyc = p;
                sbq.push_back(e);
                p += RPER;
            end
        end
`else
        if (h < 0) $display("[TB] note: negative hold %0d", h);
`endif
    endfunction

    always @(negedge clk) begin : monitor
        logic [2:0] obs;
        exp_t       e;
        obs = {clr_pulse, dec_pulse, inc_pulse};
        if (obs != 3'b000) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_pulse", 32'(obs), 32'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("pulse_cycle", cyc, e.cyc);
                checkOutput("pulse_kind", 32'(obs), 32'(e.kind));
            end
        end
    end

    initial begin
        int c;
        applyStimulus(1'b1, 1'b1, 1'b1);
        rst = 1'b1;

        // Reset held with every button pressed
        repeat (3) @(negedge clk);
        checkOutput("rst_pulses", 32'({clr_pulse, dec_pulse, inc_pulse}), 32'd0);
        checkOutput("rst_level", 32'(btn_level), 32'd0);
        rst = 1'b0;
        c   = cyc;
        pushPress(3'b100, c, 12);
        repeat (DEB + 4) @(negedge clk);
        checkOutput("rst_rel_level", 32'(btn_level), 32'b111);
        repeat (12 - (DEB + 4)) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("rst_drain", sbq.size(), 0);

        // Clean increment press
        c = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushPress(3'b001, c, 30);
        repeat (DEB + 4) @(negedge clk);
        checkOutput("inc_level", 32'(btn_level), 32'b001);
        repeat (30 - (DEB + 4)) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        checkOutput("inc_rel_level", 32'(btn_level), 32'b000);
        checkOutput("inc_drain", sbq.size(), 0);

        // Clean decrement press
        c = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushPress(3'b010, c, 10);
        repeat (10) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        checkOutput("dec_drain", sbq.size(), 0);

        // Bouncing decrement never qualifies
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, (k % 4) != 3, 1'b0);
            @(negedge clk);
            checkOutput("bounce_level", 32'(btn_level[1]), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("bounce_tail_level", 32'(btn_level[1]), 32'd0);
        end

        // Increment and decrement together cancel
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (DEB + 4) @(negedge clk);
        checkOutput("both_level", 32'(btn_level), 32'b011);
        repeat (30 - (DEB + 4)) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (15) @(negedge clk);

        // All three together: clear only
        c = cyc;
        applyStimulus(1'b1, 1'b1, 1'b1);
        pushPress(3'b100, c, 12);
        repeat (12) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        checkOutput("all_drain", sbq.size(), 0);

        // Reset in the middle of a held increment
        c = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushPress(3'b001, c, 15);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_level", 32'(btn_level), 32'd0);
        rst = 1'b0;
        c   = cyc;
        pushPress(3'b001, c, 23);
        repeat (23) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("midrst_drain", sbq.size(), 0);

        // Long hold on increment
        c = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushPress(3'b001, c, 60);
        repeat (60) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (25) @(negedge clk);
        checkOutput("hold_drain", sbq.size(), 0);
        checkOutput("final_level", 32'(btn_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
